hazard_control: RTL

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_control.sv
// Hazard unit for the 5-stage core: load-use stall, branch flush,
// EX operand forwarding selects and a drain-then-halt sequence.
module hazard_control #(
   parameter int REGBITS = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [REGBITS-1:0] id_rn,
   input  logic [REGBITS-1:0] id_rm,
   input  logic               id_uses_rn,
   input  logic               id_uses_rm,
   input  logic [REGBITS-1:0] id_rd,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               ex_branch_taken,
   input  logic               halt_req,
   output logic               pc_write,
   output logic               ifid_write,
   output logic               ifid_flush,
   output logic               idex_bubble,
   output logic [1:0]         fwd_a,
   output logic [1:0]         fwd_b,
   output logic               halted,
   output logic [15:0]        stall_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic [1:0]  drain_q, drain_d;
   logic [15:0] stall_count_q, stall_count_d;

   logic               ex_valid_q, ex_valid_d;
   logic [REGBITS-1:0] ex_rd_q, ex_rd_d;
   logic               ex_rw_q, ex_rw_d;
   logic               ex_mr_q, ex_mr_d;
   logic [REGBITS-1:0] ex_rn_q, ex_rn_d;
   logic [REGBITS-1:0] ex_rm_q, ex_rm_d;
   logic               ex_urn_q, ex_urn_d;
   logic               ex_urm_q, ex_urm_d;

   logic               mem_valid_q, mem_valid_d;
   logic [REGBITS-1:0] mem_rd_q, mem_rd_d;
   logic               mem_rw_q, mem_rw_d;

   logic               wb_valid_q, wb_valid_d;
   logic [REGBITS-1:0] wb_rd_q, wb_rd_d;
   logic               wb_rw_q, wb_rw_d;

   logic br;
   logic hazard;

   assign stall_count = stall_count_q;

   always_comb begin
      br = ex_branch_taken & ~reset;
      hazard = ex_valid_q & ex_mr_q & ex_rw_q &
               (((ex_rd_q == id_rn) & id_uses_rn) |
                ((ex_rd_q == id_rm) & id_uses_rm));
   end

   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      stall_count_d = stall_count_q;
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      halted        = 1'b0;
      unique case (state_q)
         RUN, STALL: begin
            if (br) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (hazard) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
            end
            // A halt request supersedes the stall and is not counted
            if (halt_req) begin
               state_d = DRAIN;
               drain_d = 2'd0;
            end else if (hazard && !br) begin
               state_d = STALL;
               if (stall_count_q != 16'hFFFF)
                  stall_count_d = stall_count_q + 16'd1;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = br;
            drain_d     = drain_q + 2'd1;
            if (drain_q == 2'd2)
               state_d = HALTED;
         end
         HALTED: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            halted      = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      ex_valid_d  = ~idex_bubble;
      ex_rd_d     = id_rd;
      ex_rw_d     = id_regwrite;
      ex_mr_d     = id_memread;
      ex_rn_d     = id_rn;
      ex_rm_d     = id_rm;
      ex_urn_d    = id_uses_rn;
      ex_urm_d    = id_uses_rm;
      mem_valid_d = ex_valid_q & (state_q != HALTED);
      mem_rd_d    = ex_rd_q;
      mem_rw_d    = ex_rw_q;
      wb_valid_d  = mem_valid_q & (state_q != HALTED);
      wb_rd_d     = mem_rd_q;
      wb_rw_d     = mem_rw_q;
   end

   // MEM result is younger than WB, so it wins a double match
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ex_valid_q && ex_urn_q) begin
         if (mem_valid_q && mem_rw_q && (mem_rd_q == ex_rn_q))
            fwd_a = 2'b10;
         else if (wb_valid_q && wb_rw_q && (wb_rd_q == ex_rn_q))
            fwd_a = 2'b01;
      end
      if (ex_valid_q && ex_urm_q) begin
         if (mem_valid_q && mem_rw_q && (mem_rd_q == ex_rm_q))
            fwd_b = 2'b10;
         else if (wb_valid_q && wb_rw_q && (wb_rd_q == ex_rm_q))
            fwd_b = 2'b01;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         drain_q       <= 2'd0;
         stall_count_q <= 16'd0;
         ex_valid_q    <= 1'b0;
         ex_rd_q       <= '0;
         ex_rw_q       <= 1'b0;
         ex_mr_q       <= 1'b0;
         ex_rn_q       <= '0;
         ex_rm_q       <= '0;
         ex_urn_q      <= 1'b0;
         ex_urm_q      <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_rd_q      <= '0;
         mem_rw_q      <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_rw_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         drain_q       <= drain_d;
         stall_count_q <= stall_count_d;
         ex_valid_q    <= ex_valid_d;
         ex_rd_q       <= ex_rd_d;
         ex_rw_q       <= ex_rw_d;
         ex_mr_q       <= ex_mr_d;
         ex_rn_q       <= ex_rn_d;
         ex_rm_q       <= ex_rm_d;
         ex_urn_q      <= ex_urn_d;
         ex_urm_q      <= ex_urm_d;
         mem_valid_q   <= mem_valid_d;
         mem_rd_q      <= mem_rd_d;
         mem_rw_q      <= mem_rw_d;
         wb_valid_q    <= wb_valid_d;
         wb_rd_q       <= wb_rd_d;
         wb_rw_q       <= wb_rw_d;
      end
   end

endmodule
